// File: rtl/ecap5_dwbuart_host_if.sv
// Wishbone B4 pipelined bus bundle between the UART host (master) and the
// ecap5_dwbuart register block (slave).
interface ecap5_dwbuart_host_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        stall;

  modport master (
    output adr, wdat, we, sel, stb, cyc,
    input  rdat, ack, stall
  );

  modport slave (
    input  adr, wdat, we, sel, stb, cyc,
    output rdat, ack, stall
  );
endinterface

// File: rtl/ecap5_dwbuart_host.sv
// Wishbone initiator that configures one ecap5_dwbuart, then polls its status
// register and moves bytes between the UART data registers and two 1-entry streams.
module ecap5_dwbuart_host #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] CR_VALUE  = 32'h0080_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ecap5_dwbuart_host_if.master        wb,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        err_pe_o,
  output logic                        err_fe_o,
  output logic                        err_oe_o,
  output logic                        cfg_done_o
);

  localparam logic [31:0] SR_ADDR   = BASE_ADDR;
  localparam logic [31:0] CR_ADDR   = BASE_ADDR + 32'h4;
  localparam logic [31:0] RXDR_ADDR = BASE_ADDR + 32'h8;
  localparam logic [31:0] TXDR_ADDR = BASE_ADDR + 32'hC;

  typedef enum logic [3:0] {
    CFG_REQ, CFG_WAIT, GAP, SR_REQ, SR_WAIT, RX_REQ, RX_WAIT, TX_REQ, TX_WAIT
  } state_t;

  typedef enum logic [1:0] {OP_SR, OP_RX, OP_TX} op_t;

  state_t      state;
  op_t         next_op;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        tx_full;
  logic [7:0]  tx_byte;
  logic        bus_done;
  logic        unused_rdat;

  function automatic state_t wait_of(input state_t s);
    case (s)
      CFG_REQ: return CFG_WAIT;
      SR_REQ:  return SR_WAIT;
      RX_REQ:  return RX_WAIT;
      default: return TX_WAIT;
    endcase
  endfunction

  assign wb.cyc  = cyc_q;
  assign wb.stb  = stb_q;
  assign wb.we   = we_q;
  assign wb.adr  = adr_q;
  assign wb.wdat = dat_q;
  assign wb.sel  = 4'hF;

  assign tx_ready_o  = cfg_done_o & ~tx_full;
  assign unused_rdat = ^wb.rdat[31:8];

  // An ack completes the access in WAIT, or in REQ only in the cycle the strobe is accepted.
  assign bus_done = cyc_q & wb.ack & (~stb_q | ~wb.stall);

  // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
  // blocking assignments would let later lines see this cycle's new values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CFG_REQ;
      next_op    <= OP_SR;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      tx_full    <= 1'b0;
      tx_byte    <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      err_pe_o   <= 1'b0;
      err_fe_o   <= 1'b0;
      err_oe_o   <= 1'b0;
      cfg_done_o <= 1'b0;
    end else begin
      err_pe_o <= 1'b0;
      err_fe_o <= 1'b0;
      err_oe_o <= 1'b0;

      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (tx_valid_i && tx_ready_o) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data_i;
      end

      if (bus_done) begin
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        state   <= GAP;
        next_op <= OP_SR;
        case (state)
          CFG_REQ, CFG_WAIT: cfg_done_o <= 1'b1;
          SR_REQ, SR_WAIT: begin
            err_pe_o <= wb.rdat[4];
            err_fe_o <= wb.rdat[3];
            err_oe_o <= wb.rdat[2];
            // Receive wins; a full rx register leaves RXDR in the UART untouched.
            if (wb.rdat[0] && !rx_valid_o)   next_op <= OP_RX;
            else if (wb.rdat[1] && tx_full)  next_op <= OP_TX;
          end
          RX_REQ, RX_WAIT: begin
            rx_data_o  <= wb.rdat[7:0];
            rx_valid_o <= 1'b1;
          end
          TX_REQ, TX_WAIT: tx_full <= 1'b0;
          default: ;
        endcase
      end else if (stb_q && !wb.stall) begin
        stb_q <= 1'b0;
        state <= wait_of(state);
      end else if (!cyc_q && (state == CFG_REQ || state == GAP)) begin
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
        if (state == CFG_REQ) begin
          adr_q <= CR_ADDR;
          we_q  <= 1'b1;
          dat_q <= CR_VALUE;
        end else begin
          case (next_op)
            OP_RX: begin
              adr_q <= RXDR_ADDR;
              we_q  <= 1'b0;
              state <= RX_REQ;
            end
            OP_TX: begin
              adr_q <= TXDR_ADDR;
              we_q  <= 1'b1;
              dat_q <= {24'b0, tx_byte};
              state <= TX_REQ;
            end
            default: begin
              adr_q <= SR_ADDR;
              we_q  <= 1'b0;
              state <= SR_REQ;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ecap5_dwbuart_host.sv
// Directed bench for ecap5_dwbuart_host: a negedge-driven Wishbone responder
// plus a scoreboard of expected non-status accesses.
module tb_ecap5_dwbuart_host;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       err_pe_o, err_fe_o, err_oe_o, cfg_done_o;

  ecap5_dwbuart_host_if wb();

  ecap5_dwbuart_host #(
    .BASE_ADDR (32'h0000_0000),
    .CR_VALUE  (32'h0080_0000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wb         (wb),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .err_pe_o   (err_pe_o),
    .err_fe_o   (err_fe_o),
    .err_oe_o   (err_oe_o),
    .cfg_done_o (cfg_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] sr_q[$];
  logic [31:0] rxdr_q[$];

  int total = 0;
  int bad   = 0;

  int          idle_run = 0, acc_since_rst = 0, stall_cfg = 0, stall_left = 0;
  int          stb_cycles = 0, cr_stb_cycles = 0, sr_reads = 0, cr_writes = 0;
  int          pe_cnt = 0, fe_cnt = 0, oe_cnt = 0;
  bit          in_req = 0, waiting = 0, pend_cr = 0, cr_ack_prev = 0;
  logic [31:0] ref_adr, ref_dat, pend_rdat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    acc_t e;
    e.adr = adr;
    e.we  = we;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Called by the responder in the cycle the strobe will be accepted.
  task automatic on_accept();
    acc_t e;
    check("sel_all", {28'b0, wb.sel}, 32'hF);
    pend_cr   = 0;
    pend_rdat = 32'h0;
    if (acc_since_rst == 1) begin
      check("first_adr", wb.adr, 32'h4);
      check("first_we", {31'b0, wb.we}, 32'h1);
    end
    if (wb.adr == 32'h0 && !wb.we) begin
      sr_reads++;
      if (sr_q.size() != 0) pend_rdat = sr_q.pop_front();
    end else begin
      check("unexpected_access", {31'b0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("acc_adr", wb.adr, e.adr);
        check("acc_we", {31'b0, wb.we}, {31'b0, e.we});
        if (e.we) check("acc_dat", wb.wdat, e.dat);
      end
      if (wb.adr == 32'h8 && !wb.we && rxdr_q.size() != 0) pend_rdat = rxdr_q.pop_front();
      if (wb.adr == 32'h4 && wb.we) begin
        pend_cr = 1;
        cr_writes++;
        cr_stb_cycles = stb_cycles;
      end
    end
  endtask

  // Responder: stalls a configurable number of cycles, acks one cycle after accept.
  always @(negedge clk) begin
    if (cr_ack_prev) check("cfg_done_after_ack", {31'b0, cfg_done_o}, 32'h1);
    cr_ack_prev = 0;
    wb.ack   = 1'b0;
    wb.stall = 1'b0;
    if (rst_i) acc_since_rst = 0;
    if (!wb.cyc) begin
      idle_run++;
      in_req  = 0;
      waiting = 0;
    end else begin
      if (!in_req && !waiting) begin
        if (acc_since_rst > 0) check("gap_one_cycle", idle_run, 32'd1);
        acc_since_rst++;
        in_req     = 1;
        stall_left = stall_cfg;
        stall_cfg  = 0;
        stb_cycles = 0;
        ref_adr    = wb.adr;
        ref_dat    = wb.wdat;
      end
      idle_run = 0;
      if (in_req) begin
        stb_cycles++;
        check("stb_in_req", {31'b0, wb.stb}, 32'h1);
        check("adr_stable", wb.adr, ref_adr);
        check("dat_stable", wb.wdat, ref_dat);
        if (stall_left > 0) begin
          wb.stall = 1'b1;
          stall_left--;
        end else begin
          in_req  = 0;
          waiting = 1;
          on_accept();
        end
      end else begin
        check("stb_in_wait", {31'b0, wb.stb}, 32'h0);
        wb.ack  = 1'b1;
        wb.rdat = pend_rdat;
        waiting = 0;
        if (pend_cr) begin
          check("cfg_done_before_ack", {31'b0, cfg_done_o}, 32'h0);
          cr_ack_prev = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (err_pe_o) pe_cnt++;
    if (err_fe_o) fe_cnt++;
    if (err_oe_o) oe_cnt++;
  end

  task automatic reset_dut(input int stall);
    rst_i      = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'b0, wb.cyc}, 32'h0);
    check("rst_stb", {31'b0, wb.stb}, 32'h0);
    check("rst_we", {31'b0, wb.we}, 32'h0);
    check("rst_adr", wb.adr, 32'h0);
    check("rst_dat", wb.wdat, 32'h0);
    check("rst_tx_ready", {31'b0, tx_ready_o}, 32'h0);
    check("rst_rx_valid", {31'b0, rx_valid_o}, 32'h0);
    check("rst_rx_data", {24'b0, rx_data_o}, 32'h0);
    check("rst_errs", {29'b0, err_pe_o, err_fe_o, err_oe_o}, 32'h0);
    check("rst_cfg_done", {31'b0, cfg_done_o}, 32'h0);
    exp_q.delete();
    sr_q.delete();
    rxdr_q.delete();
    sr_reads  = 0;
    cr_writes = 0;
    stall_cfg = stall;
    push_exp(32'h4, 1'b1, 32'h0080_0000);
    rst_i = 1'b0;
  endtask

  task automatic wait_cfg(input string tag);
    for (int i = 0; i < 200 && !cfg_done_o; i++) @(negedge clk);
    check({"cfg_done_", tag}, {31'b0, cfg_done_o}, 32'h1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || sr_q.size() != 0); i++) @(negedge clk);
    check({"drain_", tag}, exp_q.size() + sr_q.size(), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic send_tx(input logic [7:0] b);
    for (int i = 0; i < 100 && !tx_ready_o; i++) @(negedge clk);
    check("tx_ready_wait", {31'b0, tx_ready_o}, 32'h1);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    check("tx_full_blocks", {31'b0, tx_ready_o}, 32'h0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    rx_ready_i = 1'b0;
    @(negedge clk);

    // 1) Plain CR write, then status polling begins.
    reset_dut(0);
    wait_cfg("t1");
    check("t1_cr_stb_cycles", cr_stb_cycles, 32'd1);
    for (int i = 0; i < 100 && sr_reads < 2; i++) @(negedge clk);
    check("t1_sr_polls", {31'b0, sr_reads >= 2}, 32'h1);

    // 2) CR write stalled three cycles.
    reset_dut(3);
    wait_cfg("t2");
    check("t2_cr_stb_cycles", cr_stb_cycles, 32'd4);
    for (int i = 0; i < 100 && sr_reads < 3; i++) @(negedge clk);
    check("t2_single_cr_write", cr_writes, 32'd1);

    // 3) SR=0x3 with a tx byte pending: RXDR read first, TXDR write after.
    send_tx(8'h5A);
    push_exp(32'h8, 1'b0, 32'h0);
    push_exp(32'hC, 1'b1, 32'h0000_005A);
    rxdr_q.push_back(32'h0000_0011);
    sr_q.push_back(32'h3);
    sr_q.push_back(32'h2);
    wait_drain("t3");
    check("t3_rx_valid", {31'b0, rx_valid_o}, 32'h1);
    check("t3_rx_data", {24'b0, rx_data_o}, 32'h11);
    check("t3_tx_ready_after", {31'b0, tx_ready_o}, 32'h1);
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    check("t3_rx_consumed", {31'b0, rx_valid_o}, 32'h0);

    // 4) Full rx register blocks further RXDR reads until consumed.
    push_exp(32'h8, 1'b0, 32'h0);
    rxdr_q.push_back(32'h0000_00A5);
    sr_q.push_back(32'h1);
    sr_q.push_back(32'h1);
    sr_q.push_back(32'h1);
    wait_drain("t4a");
    check("t4_rx_valid_held", {31'b0, rx_valid_o}, 32'h1);
    check("t4_rx_data_held", {24'b0, rx_data_o}, 32'hA5);
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    check("t4_rx_consumed", {31'b0, rx_valid_o}, 32'h0);
    push_exp(32'h8, 1'b0, 32'h0);
    rxdr_q.push_back(32'h0000_003C);
    sr_q.push_back(32'h1);
    wait_drain("t4b");
    check("t4_rx_data_next", {24'b0, rx_data_o}, 32'h3C);
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;

    // 5) Error flags pulse one cycle per status read that reports them.
    pe_cnt = 0;
    fe_cnt = 0;
    oe_cnt = 0;
    sr_q.push_back(32'h1C);
    sr_q.push_back(32'h08);
    wait_drain("t5");
    check("t5_pe_pulses", pe_cnt, 32'd1);
    check("t5_fe_pulses", fe_cnt, 32'd2);
    check("t5_oe_pulses", oe_cnt, 32'd1);

    // 6) Reset while the TXDR write waits for its ack.
    send_tx(8'h77);
    push_exp(32'hC, 1'b1, 32'h0000_0077);
    sr_q.push_back(32'h2);
    for (int i = 0; i < 200 && !(wb.cyc && !wb.stb && wb.we && wb.adr == 32'hC); i++)
      @(negedge clk);
    check("t6_in_tx_wait", {31'b0, wb.cyc && !wb.stb && wb.we && wb.adr == 32'hC}, 32'h1);
    rst_i = 1'b1;
    @(negedge clk);
    check("t6_cyc_dropped", {31'b0, wb.cyc}, 32'h0);
    check("t6_tx_ready_low", {31'b0, tx_ready_o}, 32'h0);
    reset_dut(0);
    wait_cfg("t6");
    check("t6_tx_empty_after", {31'b0, tx_ready_o}, 32'h1);
    repeat (10) @(negedge clk);
    check("t6_single_cr_write", cr_writes, 32'd1);
    check("final_scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
